instr_issue_ctrl: RTL and testbench

- Sequencing controller for the 32-entry instruction register. It uses the register as a circular instruction queue.
- Write side: accepts instructions from a producer over a valid/ready handshake and drives the register's write_pointer and load_en.
- Read side: steps read_pointer and captures instruction_word into a registered issue stage for the execute unit, also over valid/ready.
- Owns all occupancy, pointer and flush bookkeeping. The register itself stays a plain storage array: synchronous write on load_en, combinational read on read_pointer.

---
 rtl/instr_issue_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_instr_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_ctrl.sv
// -----------------------------------------------------------------------------
// instr_issue_ctrl
//
// Sequencing controller for a 32-entry instruction register that is used as a
// circular instruction queue. The register itself is plain storage
// (synchronous write on load_en, combinational read on read_pointer). This
// block owns all occupancy, pointer and flush bookkeeping. It also owns a
// registered issue stage that presents one instruction at a time to the
// execute unit.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   flush             synchronous queue clear; overrides write and issue
//   wr_valid/ready    producer handshake
//   wr_opcode/op_a/b  producer instruction fields
//   load_en           register write enable
//   write_pointer     register write address
//   opcode/operand_*  register write data (wr_* passed through)
//   read_pointer      register read address
//   instruction_word  register read data, packed {opc, op_a, op_b}
//   iss_valid/ready   execute-unit handshake
//   iss_opcode/op_a/b issued instruction fields (registered)
//   count             entries stored in the register, excluding the issue stage
//   full, empty       decoded from count
//
// Optional feature (macro INSTR_ISSUE_CTRL_STATS_EN)
//   issued_cnt        saturating count of edges with iss_valid & iss_ready
//   stall_cnt         saturating count of edges with iss_valid & !iss_ready
//   Both counters are cleared by reset and by flush. When the macro is not
//   defined, these ports and their logic are absent.
// -----------------------------------------------------------------------------
module instr_issue_ctrl #(
  parameter int DEPTH  = 32,
  parameter int PTR_W  = 5,
  parameter int OPC_W  = 4,
  parameter int OPND_W = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic        [OPC_W-1:0]        wr_opcode,
  input  logic signed [OPND_W-1:0]       wr_op_a,
  input  logic signed [OPND_W-1:0]       wr_op_b,
  output logic                           load_en,
  output logic        [PTR_W-1:0]        write_pointer,
  output logic        [OPC_W-1:0]        opcode,
  output logic signed [OPND_W-1:0]       operand_a,
  output logic signed [OPND_W-1:0]       operand_b,
  output logic        [PTR_W-1:0]        read_pointer,
  input  logic        [OPC_W+2*OPND_W-1:0] instruction_word,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic        [OPC_W-1:0]        iss_opcode,
  output logic signed [OPND_W-1:0]       iss_op_a,
  output logic signed [OPND_W-1:0]       iss_op_b,
  output logic        [PTR_W:0]          count,
  output logic                           full,
`ifdef INSTR_ISSUE_CTRL_STATS_EN
  output logic                           empty,
  output logic        [15:0]             issued_cnt,
  output logic        [15:0]             stall_cnt
`else
  output logic                           empty
`endif
);

  localparam int              IW       = OPC_W + 2 * OPND_W;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic                      capture;
  logic        [PTR_W-1:0]   wr_ptr;
  logic        [PTR_W-1:0]   rd_ptr;

  // Read-data fields of the entry currently addressed by rd_ptr.
  logic        [OPC_W-1:0]   rd_opc;
  logic signed [OPND_W-1:0]  rd_op_a;
  logic signed [OPND_W-1:0]  rd_op_b;

  assign rd_opc  = instruction_word[IW-1 -: OPC_W];
  assign rd_op_a = $signed(instruction_word[2*OPND_W-1 -: OPND_W]);
  assign rd_op_b = $signed(instruction_word[OPND_W-1:0]);

  // ---- write side (combinational) ----
  // The write path looks only at full and flush, never at the read side, so
  // a full queue refuses a write even when a capture frees an entry that edge.
  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign wr_ready      = !full && !flush;
  assign load_en       = wr_valid && wr_ready;
  assign write_pointer = wr_ptr;
  assign opcode        = wr_opcode;
  assign operand_a     = wr_op_a;
  assign operand_b     = wr_op_b;
  assign read_pointer  = rd_ptr;
  assign iss_valid     = (state_q == ISSUE);

  // ---- issue-stage FSM: next state and capture decision ----
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A stalled stage holds; an accepted one refills in the same edge
        // when something is stored, so back-to-back issue has no bubble.
        if (iss_ready) begin
          if (!empty) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      capture = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- pointer and occupancy bookkeeping ----
  // Pointers wrap by natural PTR_W overflow (DEPTH is a power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (load_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (capture) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({load_en, capture})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- issue stage data register ----
  // Only a capture loads it, so it is naturally stable across stalls and
  // keeps its last contents across a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_opcode <= '0;
      iss_op_a   <= '0;
      iss_op_b   <= '0;
    end else if (capture) begin
      iss_opcode <= rd_opc;
      iss_op_a   <= rd_op_a;
      iss_op_b   <= rd_op_b;
    end
  end

`ifdef INSTR_ISSUE_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  // ---- activity statistics ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else if (flush) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (iss_valid && iss_ready) begin
        issued_cnt <= sat_inc(issued_cnt);
      end
      if (iss_valid && !iss_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for instr_issue_ctrl. Provides the 32-entry storage array, drives
// directed and randomized traffic, and checks the controller against a
// queue-based reference model. Accepted instructions are pushed into a
// scoreboard; a separate monitor compares and pops whenever the DUT issues.
// -----------------------------------------------------------------------------
module tb_instr_issue_ctrl;

  localparam int DEPTH  = 32;
  localparam int PTR_W  = 5;
  localparam int OPC_W  = 4;
  localparam int OPND_W = 32;
  localparam int IW     = OPC_W + 2 * OPND_W;

  typedef struct packed {
    logic        [OPC_W-1:0]  opc;
    logic signed [OPND_W-1:0] a;
    logic signed [OPND_W-1:0] b;
  } instr_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     flush = 1'b0;
  logic                     wr_valid = 1'b0;
  logic                     wr_ready;
  logic        [OPC_W-1:0]  wr_opcode = '0;
  logic signed [OPND_W-1:0] wr_op_a = '0;
  logic signed [OPND_W-1:0] wr_op_b = '0;
  logic                     load_en;
  logic        [PTR_W-1:0]  write_pointer;
  logic        [OPC_W-1:0]  opcode;
  logic signed [OPND_W-1:0] operand_a;
  logic signed [OPND_W-1:0] operand_b;
  logic        [PTR_W-1:0]  read_pointer;
  logic        [IW-1:0]     instruction_word;
  logic                     iss_valid;
  logic                     iss_ready = 1'b0;
  logic        [OPC_W-1:0]  iss_opcode;
  logic signed [OPND_W-1:0] iss_op_a;
  logic signed [OPND_W-1:0] iss_op_b;
  logic        [PTR_W:0]    count;
  logic                     full;
  logic                     empty;
`ifdef INSTR_ISSUE_CTRL_STATS_EN
  logic        [15:0]       issued_cnt;
  logic        [15:0]       stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int     m_cnt = 0;
  bit     m_iv  = 1'b0;
  int     m_wp  = 0;
  int     m_rp  = 0;
  int     m_iss = 0;
  int     m_stl = 0;
  instr_t sb[$];

  instr_issue_ctrl #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .OPC_W(OPC_W), .OPND_W(OPND_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_opcode(wr_opcode), .wr_op_a(wr_op_a), .wr_op_b(wr_op_b),
    .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_pointer(read_pointer), .instruction_word(instruction_word),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_op_a(iss_op_a), .iss_op_b(iss_op_b),
    .count(count), .full(full),
`ifdef INSTR_ISSUE_CTRL_STATS_EN
    .empty(empty), .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`else
    .empty(empty)
`endif
  );

  always #5 clk = ~clk;

  // Instruction register: synchronous write, combinational read.
  logic [IW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
  end
  assign instruction_word = mem[read_pointer];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_wr(input bit v);
    wr_valid  = v;
    wr_opcode = OPC_W'($urandom);
    wr_op_a   = $signed($urandom);
    wr_op_b   = $signed($urandom);
  endtask

  task automatic check_stats();
`ifdef INSTR_ISSUE_CTRL_STATS_EN
    chk("issued_cnt", issued_cnt, m_iss);
    chk("stall_cnt", stall_cnt, m_stl);
`endif
  endtask

  // Async reset pulse starting away from the clock edge; outputs are checked
  // while reset is still high.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_cnt = 0; m_iv = 1'b0; m_wp = 0; m_rp = 0; m_iss = 0; m_stl = 0;
    sb.delete();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_opcode", iss_opcode, 0);
    chk("rst_iss_op_a", iss_op_a, 0);
    chk("rst_iss_op_b", iss_op_b, 0);
    chk("rst_write_pointer", write_pointer, 0);
    chk("rst_read_pointer", read_pointer, 0);
    check_stats();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock: check outputs at the falling edge against the model, then
  // advance the model with the inputs that the rising edge sees.
  task automatic step();
    bit e_full, e_wrr, e_ld, cap;
    instr_t t;
    e_full = (m_cnt == DEPTH);
    e_wrr  = !e_full && !flush;
    e_ld   = wr_valid && e_wrr;
    @(negedge clk);
    chk("count", count, m_cnt);
    chk("full", full, e_full);
    chk("empty", empty, m_cnt == 0);
    chk("wr_ready", wr_ready, e_wrr);
    chk("load_en", load_en, e_ld);
    chk("write_pointer", write_pointer, m_wp);
    chk("read_pointer", read_pointer, m_rp);
    chk("iss_valid", iss_valid, m_iv);
    check_stats();
    @(posedge clk);
    if (flush) begin
      m_cnt = 0; m_iv = 1'b0; m_wp = 0; m_rp = 0; m_iss = 0; m_stl = 0;
      sb.delete();
    end else begin
      if (m_iv && iss_ready && m_iss < 65535) m_iss++;
      if (m_iv && !iss_ready && m_stl < 65535) m_stl++;
      // Stage refills if anything is stored and the stage is empty or draining.
      cap = (m_cnt != 0) && (!m_iv || iss_ready);
      if (e_ld) begin
        t.opc = wr_opcode; t.a = wr_op_a; t.b = wr_op_b;
        sb.push_back(t);
        m_wp = (m_wp + 1) % DEPTH;
      end
      m_iv  = (m_iv && !iss_ready) || cap;
      m_cnt = m_cnt + int'(e_ld) - int'(cap);
      if (cap) m_rp = (m_rp + 1) % DEPTH;
    end
    #1;
  endtask

  // Scoreboard monitor: the presented instruction must be the oldest
  // outstanding one; it is retired when the execute unit accepts it.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && iss_valid) begin
        if (sb.size() == 0) begin
          chk("iss_unexpected", 1, 0);
        end else begin
          chk("iss_opcode", iss_opcode, sb[0].opc);
          chk("iss_op_a", iss_op_a, sb[0].a);
          chk("iss_op_b", iss_op_b, sb[0].b);
          if (iss_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    do_reset();

    // First instruction: accepted at one edge, presented after the next.
    iss_ready = 1'b1;
    wr_valid = 1'b1; wr_opcode = 4'd3; wr_op_a = -32'sd7; wr_op_b = 32'sd12;
    #1;
    chk("first_load_en", load_en, 1);
    chk("first_write_pointer", write_pointer, 0);
    step();
    set_wr(0);
    step();
    chk("first_iss_valid", iss_valid, 1);
    chk("first_iss_opcode", iss_opcode, 3);
    chk("first_iss_op_a", iss_op_a, -7);
    chk("first_iss_op_b", iss_op_b, 12);
    chk("first_count", count, 0);
    repeat (3) step();

    // Fill to full while stalled, then keep pushing against a full queue.
    iss_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin set_wr(1); step(); end
    chk("fill_count", count, DEPTH);
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_iss_valid", iss_valid, 1);
    for (int i = 0; i < 5; i++) begin set_wr(1); step(); end

    // Drain back-to-back.
    iss_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin set_wr(0); step(); end

    // Continuous write and issue.
    for (int i = 0; i < 40; i++) begin set_wr(1); step(); end
    for (int i = 0; i < 5; i++) begin set_wr(0); step(); end

    // Build count=10 with the stage occupied, then flush.
    iss_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin set_wr(1); step(); end
    chk("preflush_count", count, 10);
    flush = 1'b1; set_wr(1); step();
    flush = 1'b0; set_wr(0);
    chk("flush_count", count, 0);
    chk("flush_iss_valid", iss_valid, 0);
    chk("flush_read_pointer", read_pointer, 0);
    chk("flush_write_pointer", write_pointer, 0);
    step();
    iss_ready = 1'b1;
    set_wr(1); step();
    set_wr(0); step();
    chk("postflush_iss_valid", iss_valid, 1);
    repeat (3) step();

`ifdef INSTR_ISSUE_CTRL_STATS_EN
    do_reset();
    iss_ready = 1'b0;
    set_wr(1); step();
    set_wr(0); step();
    set_wr(1); step(); step(); step();
    set_wr(0); iss_ready = 1'b1;
    repeat (6) step();
    chk("stats_issued_4", issued_cnt, 4);
    chk("stats_stall_3", stall_cnt, 3);
    iss_ready = 1'b0;
    set_wr(1); step();
    set_wr(0); repeat (3) step();
    do_reset();
    chk("stats_issued_rst", issued_cnt, 0);
    chk("stats_stall_rst", stall_cnt, 0);
`endif

    // Randomized traffic with occasional flushes and one mid-run reset.
    for (int i = 0; i < 900; i++) begin
      if (i == 450) do_reset();
      flush = ($urandom_range(0, 59) == 0);
      iss_ready = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      set_wr($urandom_range(0, 3) != 0);
      step();
    end

    // Drain and confirm every accepted instruction was issued.
    flush = 1'b0; iss_ready = 1'b1; set_wr(0);
    guard = 0;
    while ((m_cnt != 0 || m_iv) && guard < 100) begin
      step();
      guard++;
    end
    chk("drain_bound", guard < 100, 1);
    step();
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
